// File: rtl/pkt_axis_out_pkg.sv
// Shared types and constants for the packet-to-AXI4-Stream output stage.
// Holds the FSM state encoding, FIFO entry layout and the last-beat keep helper.
package pkt_axis_out_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_DROP,
    S_TERM
  } state_t;

  localparam int DATA_W    = 64;
  localparam int KEEP_W    = 8;
  localparam int ENTRY_W   = DATA_W + KEEP_W + 2;
  localparam int TLAST_BIT = DATA_W + KEEP_W;
  localparam int TUSER_BIT = TLAST_BIT + 1;

  // Byte enables for the final word given the low three bits of the packet length.
  function automatic logic [KEEP_W-1:0] keep_from_len(input logic [2:0] rem);
    if (rem == 3'd0) begin
      return 8'hFF;
    end
    return (8'h01 << rem) - 8'h01;
  endfunction

endpackage

// File: rtl/pkt_axis_out_fifo.sv
// First-word-fall-through FIFO whose head entry is presented from a register.
// Capacity is the full 2**AW entries; the output register mirrors the head slot.
module sync_fifo_fwft #(
  parameter int WIDTH = 74,
  parameter int AW    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] r_mem [0:(1<<AW)-1];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_dout;
  logic             r_valid;

  logic             w_pop;
  logic             w_push;
  logic [AW:0]      w_rd_next;
  logic             w_avail;

  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop     = pop && r_valid;
  assign w_push    = push && (!full || w_pop);
  assign w_rd_next = r_rd_ptr + {{AW{1'b0}}, w_pop};
  assign w_avail   = (r_wr_ptr != w_rd_next);
  assign count     = r_wr_ptr - r_rd_ptr;
  assign empty     = !r_valid;
  assign dout      = r_dout;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
  end

  // The head register always reloads from the slot that will be the head after this
  // cycle's pop, so a stalled beat is re-read unchanged and never needs a bypass.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_valid  <= 1'b0;
      r_dout   <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, w_push};
      r_rd_ptr <= w_rd_next;
      r_valid  <= w_avail;
      if (w_avail) begin
        r_dout <= r_mem[w_rd_next[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/pkt_axis_out.sv
// AXI4-Stream master for assembled 64-bit packet words: adds tkeep/tlast, buffers
// bursts, and on overflow drops the packet tail and closes it with an error beat.
module pkt_axis_out
  import pkt_axis_out_pkg::*;
#(
  parameter int FIFO_AW = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                pkt_start,
  input  logic [15:0]         pkt_len,
  input  logic [DATA_W-1:0]   word_in,
  input  logic                word_strobe,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [KEEP_W-1:0]   m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic                m_axis_tuser,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                overflow
);

  localparam logic [FIFO_AW:0] LP_DEPTH = {1'b1, {FIFO_AW{1'b0}}};

  state_t             r_state;
  logic [15:0]        r_total_words;
  logic [15:0]        r_word_cnt;
  logic [KEEP_W-1:0]  r_last_keep;
  logic               r_overflow;

  logic [16:0]        w_len_sum;
  logic [15:0]        w_total_words;
  logic               w_is_last;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_space;
  logic               w_term_space;
  logic               w_push;
  logic [ENTRY_W-1:0] w_din;
  logic [ENTRY_W-1:0] w_dout;
  logic [FIFO_AW:0]   w_count;
  logic [FIFO_AW:0]   w_post_pop;

  assign w_len_sum     = {1'b0, pkt_len} + 17'd7;
  assign w_total_words = {2'b00, w_len_sum[16:3]};
  assign w_is_last     = (r_word_cnt == r_total_words - 16'd1);
  assign w_pop         = m_axis_tvalid && m_axis_tready;
  assign w_space       = !w_full || w_pop;
  assign w_post_pop    = w_count - {{FIFO_AW{1'b0}}, w_pop};
  assign w_term_space  = (w_post_pop != LP_DEPTH);

  always_comb begin
    w_push = 1'b0;
    w_din  = '0;
    if (enable) begin
      case (r_state)
        S_RECV: begin
          if (word_strobe && !pkt_start && w_space) begin
            w_push = 1'b1;
            w_din  = {1'b0, w_is_last, (w_is_last ? r_last_keep : 8'hFF), word_in};
          end
        end
        S_TERM: begin
          if (w_term_space) begin
            w_push = 1'b1;
            w_din  = {1'b1, 1'b1, 8'h00, 64'h0};
          end
        end
        default: ;
      endcase
    end
  end

  // A new pkt_start restarts framing from any state except S_TERM, which must
  // first deliver its error beat so the host sees every packet closed.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_total_words <= '0;
      r_word_cnt    <= '0;
      r_last_keep   <= '0;
      r_overflow    <= 1'b0;
    end else if (enable) begin
      if (pkt_start && r_state != S_TERM) begin
        r_total_words <= w_total_words;
        r_word_cnt    <= '0;
        r_last_keep   <= keep_from_len(pkt_len[2:0]);
        r_state       <= (pkt_len != 16'd0) ? S_RECV : S_IDLE;
      end else begin
        case (r_state)
          S_RECV: begin
            if (word_strobe) begin
              r_word_cnt <= r_word_cnt + 16'd1;
              if (w_space) begin
                if (w_is_last) r_state <= S_IDLE;
              end else begin
                r_overflow <= 1'b1;
                r_state    <= w_is_last ? S_TERM : S_DROP;
              end
            end
          end
          S_DROP: begin
            if (word_strobe) begin
              r_word_cnt <= r_word_cnt + 16'd1;
              if (w_is_last) r_state <= S_TERM;
            end
          end
          S_TERM: begin
            if (w_term_space) r_state <= S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  sync_fifo_fwft #(
    .WIDTH (ENTRY_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .din   (w_din),
    .full  (w_full),
    .pop   (w_pop),
    .dout  (w_dout),
    .empty (w_empty),
    .count (w_count)
  );

  assign m_axis_tvalid = !w_empty;
  assign m_axis_tdata  = w_dout[DATA_W-1:0];
  assign m_axis_tkeep  = w_dout[DATA_W +: KEEP_W];
  assign m_axis_tlast  = w_dout[TLAST_BIT];
  assign m_axis_tuser  = w_dout[TUSER_BIT];
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_pkt_axis_out.sv
// Scoreboard bench for pkt_axis_out: a packet-level model predicts every beat,
// and an independent monitor compares whatever the DUT transfers against it.
module tb_pkt_axis_out;

  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        pkt_start = 1'b0;
  logic [15:0] pkt_len = '0;
  logic [63:0] word_in = '0;
  logic        word_strobe = 1'b0;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        overflow;

  int vectorsApplied = 0;
  int miscompares = 0;
  int readyMode = 0;
  int beatsSeen = 0;
  int termSeen = 0;

  logic [73:0] expQ[$];
  logic [73:0] monBeat;
  logic [73:0] prevBeat;
  bit          prevStall = 0;

  bit          pktActive = 0;
  bit          dropping = 0;
  bit          termPending = 0;
  bit          lastWord;
  int          wordsLeft = 0;
  int          lastBytes;
  logic [7:0]  keepLast = '0;

  pkt_axis_out dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .pkt_start     (pkt_start),
    .pkt_len       (pkt_len),
    .word_in       (word_in),
    .word_strobe   (word_strobe),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .overflow      (overflow)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [73:0] actual, input logic [73:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Sink readiness: 0 = always ready, 1 = stalled, otherwise random.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (readyMode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = 1'b0;
        default: m_axis_tready = ($urandom_range(0, 99) < 70);
      endcase
    end
  end

  // Monitor: compares every transferred beat and checks stability while stalled.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        prevStall = 0;
      end else begin
        monBeat = {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        if (prevStall) begin
          checkOutput("hold_tvalid", 74'(m_axis_tvalid), 74'd1);
          checkOutput("hold_beat", monBeat, prevBeat);
        end
        if (m_axis_tvalid && m_axis_tready) begin
          beatsSeen++;
          if (m_axis_tuser) termSeen++;
          if (expQ.size() == 0) begin
            vectorsApplied++;
            miscompares++;
            $display("[TB] FAIL unexpected_beat: got %h, expected no beat", monBeat);
          end else begin
            checkOutput("beat", monBeat, expQ.pop_front());
          end
        end
        prevStall = m_axis_tvalid && !m_axis_tready;
        prevBeat  = monBeat;
      end
    end
  end

  // Packet-level reference: the expected queue doubles as the buffer occupancy,
  // evaluated after the monitor has retired this cycle's transfer.
  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (reset) begin
        expQ.delete();
        pktActive   = 0;
        dropping    = 0;
        termPending = 0;
      end else if (enable) begin
        if (termPending) begin
          if (expQ.size() < DEPTH) begin
            expQ.push_back({1'b1, 1'b1, 8'h00, 64'h0});
            termPending = 0;
          end
        end else if (pkt_start) begin
          pktActive = (pkt_len != 16'd0);
          dropping  = 0;
          wordsLeft = (int'(pkt_len) + 7) / 8;
          lastBytes = int'(pkt_len) - 8 * (wordsLeft - 1);
          keepLast  = 8'((1 << lastBytes) - 1);
        end else if (word_strobe && pktActive) begin
          lastWord = (wordsLeft == 1);
          wordsLeft--;
          if (!dropping && expQ.size() < DEPTH) begin
            expQ.push_back({1'b0, lastWord, (lastWord ? keepLast : 8'hFF), word_in});
            if (lastWord) pktActive = 0;
          end else begin
            dropping = 1;
            if (lastWord) begin
              pktActive   = 0;
              dropping    = 0;
              termPending = 1;
            end
          end
        end
      end
    end
  end

  task automatic applyStimulus(input int len, input int gapPct);
    int nWords;
    nWords = (len + 7) / 8;
    pkt_start = 1'b1;
    pkt_len   = 16'(len);
    tick();
    pkt_start = 1'b0;
    for (int w = 0; w < nWords; w++) begin
      while ($urandom_range(0, 99) < gapPct) tick();
      word_in     = {$urandom, $urandom};
      word_strobe = 1'b1;
      tick();
      word_strobe = 1'b0;
    end
    tick();
    tick();
  endtask

  task automatic waitDrain(input int maxCycles);
    int n;
    n = 0;
    while ((expQ.size() != 0 || termPending || m_axis_tvalid) && n < maxCycles) begin
      tick();
      n++;
    end
    if (n >= maxCycles) begin
      vectorsApplied++;
      miscompares++;
      $display("[TB] FAIL drain_timeout: got %0d beats still expected, required 0", expQ.size());
    end
    tick();
    checkOutput("drain_tvalid", 74'(m_axis_tvalid), 74'd0);
  endtask

  initial begin
    int b0;
    int t0;

    readyMode = 0;
    repeat (3) tick();
    checkOutput("rst_tvalid", 74'(m_axis_tvalid), 74'd0);
    checkOutput("rst_beat", {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, 74'd0);
    checkOutput("rst_overflow", 74'(overflow), 74'd0);
    reset  = 1'b0;
    enable = 1'b1;
    tick();

    $display("[TB] single 8-byte packet, latency");
    pkt_start = 1'b1;
    pkt_len   = 16'd8;
    tick();
    pkt_start   = 1'b0;
    word_in     = 64'h0807060504030201;
    word_strobe = 1'b1;
    tick();
    word_strobe = 1'b0;
    checkOutput("t1_tvalid_edge1", 74'(m_axis_tvalid), 74'd0);
    tick();
    checkOutput("t1_tvalid_edge2", 74'(m_axis_tvalid), 74'd1);
    checkOutput("t1_beat", {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata},
                {1'b0, 1'b1, 8'hFF, 64'h0807060504030201});
    waitDrain(50);

    $display("[TB] partial and exact last words, zero length");
    applyStimulus(13, 0);
    waitDrain(50);
    applyStimulus(16, 0);
    waitDrain(50);
    b0 = beatsSeen;
    pkt_start = 1'b1;
    pkt_len   = 16'd0;
    tick();
    pkt_start   = 1'b0;
    word_in     = {$urandom, $urandom};
    word_strobe = 1'b1;
    tick();
    word_strobe = 1'b0;
    repeat (4) tick();
    checkOutput("t3_len0_tvalid", 74'(m_axis_tvalid), 74'd0);
    checkOutput("t3_len0_beats", 74'(beatsSeen - b0), 74'd0);
    applyStimulus(8, 0);
    waitDrain(50);

    $display("[TB] overflow with stalled sink");
    readyMode = 1;
    tick();
    tick();
    b0 = beatsSeen;
    t0 = termSeen;
    pkt_start = 1'b1;
    pkt_len   = 16'd160;
    tick();
    pkt_start = 1'b0;
    for (int w = 0; w < 20; w++) begin
      if (w == 16) checkOutput("t4_ovf_before", 74'(overflow), 74'd0);
      word_in     = {$urandom, $urandom};
      word_strobe = 1'b1;
      tick();
      if (w == 16) checkOutput("t4_ovf_after", 74'(overflow), 74'd1);
    end
    word_strobe = 1'b0;
    repeat (3) tick();
    checkOutput("t4_stalled_tvalid", 74'(m_axis_tvalid), 74'd1);
    readyMode = 0;
    waitDrain(100);
    checkOutput("t4_beats", 74'(beatsSeen - b0), 74'd17);
    checkOutput("t4_term_beats", 74'(termSeen - t0), 74'd1);
    checkOutput("t4_ovf_sticky", 74'(overflow), 74'd1);

    $display("[TB] random backpressure");
    readyMode = 2;
    applyStimulus(512, 40);
    waitDrain(2000);
    for (int i = 0; i < 6; i++) begin
      applyStimulus($urandom_range(1, 120), 30);
    end
    waitDrain(2000);

    $display("[TB] reset mid-packet");
    readyMode = 1;
    tick();
    tick();
    pkt_start = 1'b1;
    pkt_len   = 16'd80;
    tick();
    pkt_start = 1'b0;
    for (int w = 0; w < 8; w++) begin
      word_in     = {$urandom, $urandom};
      word_strobe = 1'b1;
      tick();
    end
    word_strobe = 1'b0;
    tick();
    checkOutput("t6_pre_tvalid", 74'(m_axis_tvalid), 74'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("t6_tvalid", 74'(m_axis_tvalid), 74'd0);
    checkOutput("t6_overflow", 74'(overflow), 74'd0);
    readyMode = 0;
    tick();
    b0 = beatsSeen;
    applyStimulus(8, 0);
    waitDrain(50);
    checkOutput("t6_after_beats", 74'(beatsSeen - b0), 74'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
